// File: rtl/lu_pkg.sv
// -----------------------------------------------------------------------------
// lu_pkg
//   Shared types and helpers for the LU row sequencer.
//   cplx_t / row_t describe the default element and row layout
//   ({imag, real} per element, element j of a row in the j-th slot).
//   state_e enumerates the sequencer FSM; idx_w() sizes row/matrix indices.
// -----------------------------------------------------------------------------
package lu_pkg;

    localparam int unsigned LU_WIDTH = 64;
    localparam int unsigned LU_SIZE  = 4;

    // 'real' is a keyword, so the real part is called re.
    typedef struct packed {
        logic [LU_WIDTH-1:0] imag;
        logic [LU_WIDTH-1:0] re;
    } cplx_t;

    typedef cplx_t [LU_SIZE-1:0] row_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_PIV,
        ST_WAIT_PIV,
        ST_RD_ROW,
        ST_WAIT_ROW,
        ST_ELIM,
        ST_WAIT_RES,
        ST_WR_ROW,
        ST_DONE
    } state_e;

    // Index width for n items; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lu_sched_cnt.sv
// -----------------------------------------------------------------------------
// lu_sched_cnt
//   Pivot (k) / target (i) counter pair walking the elimination schedule.
//   Ports:
//     clk_i, rst_i        clock, synchronous active-high reset
//     clr                 return to k=i=0 (abort)
//     init                start a matrix: k=0, i=1
//     adv                 step after a row write-back: next target, or next
//                         pivot with i restarting at k+1
//     k, i                current pivot / target row
//     last_row            i is the bottom row
//     last_pivot          k is the bottom row
// -----------------------------------------------------------------------------
module lu_sched_cnt
    import lu_pkg::*;
#(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned ROW_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             init,
    input  logic             adv,
    output logic [ROW_W-1:0] k,
    output logic [ROW_W-1:0] i,
    output logic             last_row,
    output logic             last_pivot
);

    assign last_row   = (i == ROW_W'(SIZE - 1));
    assign last_pivot = (k == ROW_W'(SIZE - 1));

    // NOTE: state is written with <= so every register samples the
    // pre-edge values of k and i; with = the i <= k + 2 update would see
    // the already-incremented k.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            k <= '0;
            i <= '0;
        end else if (init) begin
            k <= '0;
            i <= ROW_W'(1);
        end else if (adv) begin
            if (last_row) begin
                // i wraps past the bottom on the final pivot; it is unused there.
                k <= k + ROW_W'(1);
                i <= k + ROW_W'(2);
            end else begin
                i <= i + ROW_W'(1);
            end
        end
    end

endmodule

// File: rtl/lu_row_sequencer.sv
// -----------------------------------------------------------------------------
// lu_row_sequencer
//   Sequencer for batched in-place LU decomposition. For the selected matrix
//   it reads pivot row k, streams it out as U row k, then for every row i>k
//   reads the row, hands (pivot, row, k) to the external elimination datapath,
//   streams the returned multiplier l(i,k) and writes the updated row back.
//   Memory address = {mat, row}; mat is latched at start.
//
//   Ports (all synchronous to clk_i; rst_i synchronous active-high):
//     start_i/mat_sel_i         start a matrix (IDLE only)
//     flush_i                   abort to IDLE on the next edge
//     rd_*                      row read request (valid/ready) + returned row
//     elim_*                    elimination request (valid/ready) + result
//     wr_*                      row write-back (valid/ready)
//     u_*                       final U row k (pulse)
//     l_*                       multiplier l(i,k) (pulse)
//     busy_o, done_o, err_o     status; done_o/err_o are one-cycle pulses
//
//   Build option: define LU_PIVOT_CHECK_EN to abort with err_o when pivot
//   element k has zero magnitude in both parts (sign bit ignored, so -0.0
//   also counts as zero). Without it err_o is constant 0.
// -----------------------------------------------------------------------------
module lu_row_sequencer
    import lu_pkg::*;
#(
    parameter  int unsigned SIZE    = 4,
    parameter  int unsigned WIDTH   = 64,
    parameter  int unsigned NUM_MAT = 2,
    localparam int unsigned ROW_W   = idx_w(SIZE),
    localparam int unsigned MAT_W   = idx_w(NUM_MAT),
    localparam int unsigned ELEM_W  = 2 * WIDTH,
    localparam int unsigned ROWD_W  = SIZE * ELEM_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [MAT_W-1:0]       mat_sel_i,
    input  logic                   flush_i,
    output logic [MAT_W+ROW_W-1:0] rd_addr_o,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    input  logic [ROWD_W-1:0]      rd_data_i,
    input  logic                   rd_data_valid_i,
    output logic [ROWD_W-1:0]      elim_piv_o,
    output logic [ROWD_W-1:0]      elim_row_o,
    output logic [ROW_W-1:0]       elim_k_o,
    output logic                   elim_valid_o,
    input  logic                   elim_ready_i,
    input  logic [ROWD_W-1:0]      elim_res_i,
    input  logic [ELEM_W-1:0]      elim_l_i,
    input  logic                   elim_res_valid_i,
    output logic [MAT_W+ROW_W-1:0] wr_addr_o,
    output logic [ROWD_W-1:0]      wr_data_o,
    output logic                   wr_valid_o,
    input  logic                   wr_ready_i,
    output logic [ROWD_W-1:0]      u_row_o,
    output logic [ROW_W-1:0]       u_idx_o,
    output logic                   u_valid_o,
    output logic [ELEM_W-1:0]      l_o,
    output logic [ROW_W-1:0]       l_row_o,
    output logic [ROW_W-1:0]       l_col_o,
    output logic                   l_valid_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    state_e state_q, state_d;

    logic [MAT_W-1:0]  mat_q;
    logic [ROWD_W-1:0] piv_q, row_q, res_q;
    logic              err_q;

    logic [ROW_W-1:0]  k, i;
    logic              last_row, last_pivot;
    logic              cnt_init, cnt_adv;
    logic              cap_piv, cap_row, cap_res, piv_bad;
    logic              pivot_zero;

    lu_sched_cnt #(
        .SIZE  (SIZE),
        .ROW_W (ROW_W)
    ) u_sched_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr        (flush_i),
        .init       (cnt_init),
        .adv        (cnt_adv),
        .k          (k),
        .i          (i),
        .last_row   (last_row),
        .last_pivot (last_pivot)
    );

`ifdef LU_PIVOT_CHECK_EN
    logic [ELEM_W-1:0] piv_elem;
    assign piv_elem   = rd_data_i[k*ELEM_W +: ELEM_W];
    assign pivot_zero = ~|piv_elem[WIDTH-2:0] & ~|piv_elem[ELEM_W-2:WIDTH];
`else
    assign pivot_zero = 1'b0;
`endif

    assign busy_o     = (state_q != ST_IDLE);
    assign elim_piv_o = piv_q;
    assign elim_row_o = row_q;
    assign elim_k_o   = k;
    assign wr_data_o  = res_q;
    assign err_o      = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        rd_valid_o   = 1'b0;
        rd_addr_o    = '0;
        elim_valid_o = 1'b0;
        wr_valid_o   = 1'b0;
        wr_addr_o    = '0;
        done_o       = 1'b0;
        cnt_init     = 1'b0;
        cnt_adv      = 1'b0;
        cap_piv      = 1'b0;
        cap_row      = 1'b0;
        cap_res      = 1'b0;
        piv_bad      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cnt_init = 1'b1;
                    state_d  = ST_RD_PIV;
                end
            end
            ST_RD_PIV: begin
                rd_valid_o = 1'b1;
                rd_addr_o  = {mat_q, k};
                if (rd_ready_i) state_d = ST_WAIT_PIV;
            end
            ST_WAIT_PIV: begin
                if (rd_data_valid_i) begin
                    if (pivot_zero) begin
                        piv_bad = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cap_piv = 1'b1;
                        state_d = last_pivot ? ST_DONE : ST_RD_ROW;
                    end
                end
            end
            ST_RD_ROW: begin
                rd_valid_o = 1'b1;
                rd_addr_o  = {mat_q, i};
                if (rd_ready_i) state_d = ST_WAIT_ROW;
            end
            ST_WAIT_ROW: begin
                if (rd_data_valid_i) begin
                    cap_row = 1'b1;
                    state_d = ST_ELIM;
                end
            end
            ST_ELIM: begin
                elim_valid_o = 1'b1;
                if (elim_ready_i) state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (elim_res_valid_i) begin
                    cap_res = 1'b1;
                    state_d = ST_WR_ROW;
                end
            end
            ST_WR_ROW: begin
                wr_valid_o = 1'b1;
                wr_addr_o  = {mat_q, i};
                if (wr_ready_i) begin
                    cnt_adv = 1'b1;
                    state_d = last_row ? ST_RD_PIV : ST_RD_ROW;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over any handshake completing in the same cycle.
        if (flush_i) state_d = ST_IDLE;
    end

    // NOTE: the row registers are wide but drive outputs that must read 0
    // after reset/flush, so they are cleared here rather than left unreset.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            mat_q     <= '0;
            piv_q     <= '0;
            row_q     <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            u_row_o   <= '0;
            u_idx_o   <= '0;
            u_valid_o <= 1'b0;
            l_o       <= '0;
            l_row_o   <= '0;
            l_col_o   <= '0;
            l_valid_o <= 1'b0;
        end else begin
            u_valid_o <= 1'b0;
            l_valid_o <= 1'b0;
            err_q     <= piv_bad;
            if (cnt_init) mat_q <= mat_sel_i;
            if (cap_piv) begin
                piv_q     <= rd_data_i;
                u_row_o   <= rd_data_i;
                u_idx_o   <= k;
                u_valid_o <= 1'b1;
            end
            if (cap_row) row_q <= rd_data_i;
            if (cap_res) begin
                res_q     <= elim_res_i;
                l_o       <= elim_l_i;
                l_row_o   <= i;
                l_col_o   <= k;
                l_valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lu_row_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lu_row_sequencer
//   Bench for lu_row_sequencer (SIZE=4, WIDTH=64, NUM_MAT=2) with a 1-cycle
//   row memory, a stub elimination datapath and a schedule-level reference
//   model producing the expected read/write/U/L event streams.
// -----------------------------------------------------------------------------
module tb_lu_row_sequencer;

    localparam int SIZE = 4;
    localparam int WIDTH = 64;
    localparam int NUM_MAT = 2;
    localparam int ROWD = SIZE * 2 * WIDTH;

    typedef logic [ROWD-1:0] row_t;
    typedef struct packed { logic [2:0] a; row_t d; } wr_e;
    typedef struct packed { logic [1:0] idx; row_t r; } u_e;
    typedef struct packed { logic [1:0] r; logic [1:0] c; logic [127:0] v; } l_e;

    logic clk_i = 1'b0;
    logic rst_i, start_i, flush_i;
    logic [0:0] mat_sel_i;
    logic [2:0] rd_addr_o, wr_addr_o;
    logic rd_valid_o, rd_ready_i, rd_data_valid_i;
    row_t rd_data_i, elim_piv_o, elim_row_o, elim_res_i, wr_data_o, u_row_o;
    logic [1:0] elim_k_o, u_idx_o, l_row_o, l_col_o;
    logic elim_valid_o, elim_ready_i, elim_res_valid_i;
    logic [127:0] elim_l_i, l_o;
    logic wr_valid_o, wr_ready_i, u_valid_o, l_valid_o, busy_o, done_o, err_o;

    always #5 clk_i = ~clk_i;

    lu_row_sequencer #(.SIZE(SIZE), .WIDTH(WIDTH), .NUM_MAT(NUM_MAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mat_sel_i(mat_sel_i), .flush_i(flush_i),
        .rd_addr_o(rd_addr_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_data_i(rd_data_i), .rd_data_valid_i(rd_data_valid_i),
        .elim_piv_o(elim_piv_o), .elim_row_o(elim_row_o), .elim_k_o(elim_k_o),
        .elim_valid_o(elim_valid_o), .elim_ready_i(elim_ready_i),
        .elim_res_i(elim_res_i), .elim_l_i(elim_l_i), .elim_res_valid_i(elim_res_valid_i),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
        .u_row_o(u_row_o), .u_idx_o(u_idx_o), .u_valid_o(u_valid_o),
        .l_o(l_o), .l_row_o(l_row_o), .l_col_o(l_col_o), .l_valid_o(l_valid_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [ROWD-1:0] act, input logic [ROWD-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL unexpected %s event", name);
    endtask

    // ---------------- stub elimination datapath + reference model ----------
    function automatic row_t elim_fn(input row_t piv, input row_t row, input logic [1:0] k);
        return {row[255:0], row[511:256]} ^ (piv << (k + 1));
    endfunction

    function automatic logic [127:0] l_fn(input row_t piv, input row_t row, input logic [1:0] k);
        return row[127:0] ^ piv[255:128] ^ 128'(k);
    endfunction

    function automatic bit piv_zero(input row_t r, input int k);
`ifdef LU_PIVOT_CHECK_EN
        logic [127:0] e;
        e = r[k*128 +: 128];
        return (e[62:0] == '0) && (e[126:64] == '0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic row_t rnd_row();
        row_t r;
        for (int w = 0; w < ROWD / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    row_t mem [8];
    logic [2:0] exp_rd[$];
    wr_e exp_wr[$];
    u_e  exp_u[$];
    l_e  exp_l[$];
    int  exp_done, exp_err;

    // Schedule-level model: pivot k then each lower row, rows updated in place.
    task automatic build_model(input int mat);
        row_t m [4];
        row_t res;
        exp_rd.delete(); exp_wr.delete(); exp_u.delete(); exp_l.delete();
        for (int r = 0; r < SIZE; r++) m[r] = mem[mat*SIZE + r];
        exp_done = 1;
        exp_err  = 0;
        for (int k = 0; k < SIZE; k++) begin
            exp_rd.push_back(3'(mat*SIZE + k));
            if (piv_zero(m[k], k)) begin
                exp_err = 1;
                exp_done = 0;
                break;
            end
            exp_u.push_back('{idx: 2'(k), r: m[k]});
            for (int i = k + 1; i < SIZE; i++) begin
                exp_rd.push_back(3'(mat*SIZE + i));
                res = elim_fn(m[k], m[i], 2'(k));
                exp_l.push_back('{r: 2'(i), c: 2'(k), v: l_fn(m[k], m[i], 2'(k))});
                exp_wr.push_back('{a: 3'(mat*SIZE + i), d: res});
                m[i] = res;
            end
        end
    endtask

    // ---------------- shared state between processes -----------------------
    logic rd_fire_q, wr_fire_q, el_fire_q;
    logic [2:0] rd_addr_q, wr_addr_q;
    row_t wr_data_q, el_piv_q, el_row_q;
    logic [1:0] el_k_q;
    logic rd_stall, el_stall, wr_stall;
    int rd_fires, el_fires, u_cnt, l_cnt, done_cnt, err_cnt;
    logic [2:0] rd_log[$], wr_log[$];

    bit rand_rdy = 0;
    int elim_lat = 1;
    bit start_req = 0;
    int start_mat = 0;
    int rd_hold_at = -1, rd_hold_left = 0, el_hold_at = -1, el_hold_left = 0;

    // ---------------- input driver: memory, datapath, readies, start --------
    initial begin
        bit el_pend;
        int el_cnt;
        row_t el_res;
        logic [127:0] el_l;
        el_pend = 0; el_cnt = 0; el_res = '0; el_l = '0;
        start_i = 0; mat_sel_i = 0; rd_ready_i = 0; rd_data_i = '0; rd_data_valid_i = 0;
        elim_ready_i = 0; elim_res_i = '0; elim_l_i = '0; elim_res_valid_i = 0; wr_ready_i = 0;
        forever begin
            @(posedge clk_i); #1;
            if (wr_fire_q) mem[wr_addr_q] = wr_data_q;
            if (rd_fire_q) begin
                rd_data_i = mem[rd_addr_q];
                rd_data_valid_i = 1;
            end else begin
                rd_data_i = rnd_row();
                rd_data_valid_i = 0;
            end
            if (el_fire_q) begin
                el_pend = 1;
                el_cnt = rand_rdy ? int'($urandom_range(1, 4)) : elim_lat;
                el_res = elim_fn(el_piv_q, el_row_q, el_k_q);
                el_l = l_fn(el_piv_q, el_row_q, el_k_q);
            end
            elim_res_valid_i = 0;
            elim_res_i = rnd_row();
            elim_l_i = {$urandom, $urandom, $urandom, $urandom};
            if (el_pend) begin
                if (el_cnt <= 1) begin
                    elim_res_valid_i = 1;
                    elim_res_i = el_res;
                    elim_l_i = el_l;
                    el_pend = 0;
                end else begin
                    el_cnt--;
                end
            end
            rd_ready_i   = rand_rdy ? ($urandom % 4 != 0) : 1'b1;
            elim_ready_i = rand_rdy ? ($urandom % 4 != 0) : 1'b1;
            wr_ready_i   = rand_rdy ? ($urandom % 4 != 0) : 1'b1;
            if (rd_hold_left > 0 && rd_fires == rd_hold_at && rd_valid_o) begin
                rd_ready_i = 0;
                rd_hold_left--;
            end
            if (el_hold_left > 0 && el_fires == el_hold_at && elim_valid_o) begin
                elim_ready_i = 0;
                el_hold_left--;
            end
            start_i = 0;
            mat_sel_i = 1'($urandom);
            if (start_req) begin
                start_i = 1;
                mat_sel_i = 1'(start_mat);
                start_req = 0;
            end else if (rand_rdy && busy_o && ($urandom % 8 == 0)) begin
                start_i = 1;
            end
        end
    end

    // ---------------- compare process (opposite edge) -----------------------
    initial begin
        u_e ue;
        l_e le;
        wr_e we;
        rd_fire_q = 0; wr_fire_q = 0; el_fire_q = 0;
        rd_stall = 0; el_stall = 0; wr_stall = 0;
        rd_fires = 0; el_fires = 0; u_cnt = 0; l_cnt = 0; done_cnt = 0; err_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i !== 1'b0) begin
                rd_fire_q = 0; wr_fire_q = 0; el_fire_q = 0;
                rd_stall = 0; el_stall = 0; wr_stall = 0;
            end else begin
                if (rd_stall) begin
                    check("rd_valid held", rd_valid_o, 1'b1);
                    check("rd_addr held", rd_addr_o, rd_addr_q);
                end
                if (el_stall) begin
                    check("elim_valid held", elim_valid_o, 1'b1);
                    check("elim_piv held", elim_piv_o, el_piv_q);
                    check("elim_row held", elim_row_o, el_row_q);
                    check("elim_k held", elim_k_o, el_k_q);
                end
                if (wr_stall) begin
                    check("wr_valid held", wr_valid_o, 1'b1);
                    check("wr_addr held", wr_addr_o, wr_addr_q);
                    check("wr_data held", wr_data_o, wr_data_q);
                end
                if (elim_valid_o) check("no read during elim", rd_valid_o, 1'b0);

                rd_fire_q = rd_valid_o && rd_ready_i;  rd_addr_q = rd_addr_o;
                el_fire_q = elim_valid_o && elim_ready_i;
                el_piv_q = elim_piv_o; el_row_q = elim_row_o; el_k_q = elim_k_o;
                wr_fire_q = wr_valid_o && wr_ready_i;
                wr_addr_q = wr_addr_o; wr_data_q = wr_data_o;
                rd_stall = rd_valid_o && !rd_ready_i && !flush_i;
                el_stall = elim_valid_o && !elim_ready_i && !flush_i;
                wr_stall = wr_valid_o && !wr_ready_i && !flush_i;

                if (rd_fire_q) begin
                    rd_fires++;
                    rd_log.push_back(rd_addr_o);
                    if (exp_rd.size() == 0) unexpected("read");
                    else check("read addr", rd_addr_o, exp_rd.pop_front());
                end
                if (el_fire_q) el_fires++;
                if (wr_fire_q) begin
                    wr_log.push_back(wr_addr_o);
                    if (exp_wr.size() == 0) unexpected("write");
                    else begin
                        we = exp_wr.pop_front();
                        check("write addr", wr_addr_o, we.a);
                        check("write data", wr_data_o, we.d);
                    end
                end
                if (u_valid_o) begin
                    u_cnt++;
                    if (exp_u.size() == 0) unexpected("U row");
                    else begin
                        ue = exp_u.pop_front();
                        check("u_idx", u_idx_o, ue.idx);
                        check("u_row", u_row_o, ue.r);
                    end
                end
                if (l_valid_o) begin
                    l_cnt++;
                    if (exp_l.size() == 0) unexpected("L element");
                    else begin
                        le = exp_l.pop_front();
                        check("l_row", l_row_o, le.r);
                        check("l_col", l_col_o, le.c);
                        check("l value", l_o, le.v);
                    end
                end
                if (done_o) done_cnt++;
                if (err_o) err_cnt++;
            end
        end
    end

    // ---------------- sequences ---------------------------------------------
    task automatic begin_run(input int mat);
        build_model(mat);
        done_cnt = 0; err_cnt = 0; u_cnt = 0; l_cnt = 0;
        rd_fires = 0; el_fires = 0;
        rd_log.delete(); wr_log.delete();
        start_mat = mat;
        start_req = 1;
    endtask

    task automatic run_matrix(input int mat, input string tag);
        begin_run(mat);
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk_i);
            if (done_cnt != 0 || err_cnt != 0) break;
        end
        repeat (6) @(posedge clk_i);
        #1;
        check({tag, " done pulses"}, done_cnt, exp_done);
        check({tag, " err pulses"}, err_cnt, exp_err);
        check({tag, " reads left"}, exp_rd.size(), 0);
        check({tag, " writes left"}, exp_wr.size(), 0);
        check({tag, " U left"}, exp_u.size(), 0);
        check({tag, " L left"}, exp_l.size(), 0);
        check({tag, " idle busy"}, busy_o, 1'b0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rd_lit [10];
        logic [2:0] wr_lit [6];
        rd_lit = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd5, 3'd6, 3'd7, 3'd6, 3'd7, 3'd7};
        wr_lit = '{3'd5, 3'd6, 3'd7, 3'd6, 3'd7, 3'd7};
        rst_i = 1;
        flush_i = 0;
        for (int r = 0; r < 8; r++) mem[r] = rnd_row();

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst busy", busy_o, 1'b0);
        check("rst rd_valid", rd_valid_o, 1'b0);
        check("rst rd_addr", rd_addr_o, 3'd0);
        check("rst elim_valid", elim_valid_o, 1'b0);
        check("rst elim_piv", elim_piv_o, '0);
        check("rst elim_row", elim_row_o, '0);
        check("rst elim_k", elim_k_o, 2'd0);
        check("rst wr_valid", wr_valid_o, 1'b0);
        check("rst wr_addr", wr_addr_o, 3'd0);
        check("rst wr_data", wr_data_o, '0);
        check("rst u_valid", u_valid_o, 1'b0);
        check("rst u_row", u_row_o, '0);
        check("rst u_idx", u_idx_o, 2'd0);
        check("rst l_valid", l_valid_o, 1'b0);
        check("rst l", l_o, '0);
        check("rst l_row", l_row_o, 2'd0);
        check("rst l_col", l_col_o, 2'd0);
        check("rst done", done_o, 1'b0);
        check("rst err", err_o, 1'b0);
        rst_i = 0;
        repeat (2) @(posedge clk_i);

        // Matrix 1, always-ready: literal schedule pins the model
        run_matrix(1, "basic");
        check("basic read count", rd_log.size(), 10);
        if (rd_log.size() == 10)
            for (int j = 0; j < 10; j++) check("basic read seq", rd_log[j], rd_lit[j]);
        check("basic write count", wr_log.size(), 6);
        if (wr_log.size() == 6)
            for (int j = 0; j < 6; j++) check("basic write seq", wr_log[j], wr_lit[j]);
        check("basic U count", u_cnt, 4);
        check("basic L count", l_cnt, 6);
        check("basic done once", done_cnt, 1);

        // Read stall on the first target read
        rd_hold_at = 1; rd_hold_left = 3;
        run_matrix(0, "rd stall");
        check("rd stall read count", rd_log.size(), 10);

        // Elimination stall on the first request
        el_hold_at = 0; el_hold_left = 5;
        run_matrix(1, "elim stall");

        // Flush while waiting for the (k=1, i=2) result
        elim_lat = 3;
        begin_run(0);
        for (int c = 0; c < 2000 && el_fires < 4; c++) @(posedge clk_i);
        check("flush reached elim 4", el_fires, 4);
        @(posedge clk_i); #1;
        flush_i = 1;
        exp_rd.delete(); exp_wr.delete(); exp_u.delete(); exp_l.delete();
        @(posedge clk_i); #1;
        flush_i = 0;
        check("flush busy", busy_o, 1'b0);
        for (int c = 0; c < 10; c++) begin
            check("flush no write", wr_valid_o, 1'b0);
            @(posedge clk_i); #1;
        end
        check("flush done", done_cnt, 0);
        check("flush err", err_cnt, 0);
        elim_lat = 1;

`ifdef LU_PIVOT_CHECK_EN
        // -0.0 + j(-0.0) pivot at row 0 column 0
        mem[0][127:0] = {64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        run_matrix(0, "zero pivot");
        check("zero pivot err once", err_cnt, 1);
        check("zero pivot no writes", wr_log.size(), 0);
        check("zero pivot no U", u_cnt, 0);
        check("zero pivot no done", done_cnt, 0);
        mem[0] = rnd_row();
`endif

        // Randomised runs: random contents, readies, latencies, stray starts
        rand_rdy = 1;
        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < 8; r++) mem[r] = rnd_row();
            run_matrix(int'($urandom % NUM_MAT), "random");
        end
        rand_rdy = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
